// File: rtl/decode_stage.sv
// RV32I decode/issue stage: decodes one instruction per handshake into a registered
// operand/ALU-op bundle for the execute stage.

package decode_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL = 4'd2,  ALU_LT  = 4'd3,
    ALU_LTU = 4'd4,  ALU_XOR = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
    ALU_OR  = 4'd8,  ALU_AND = 4'd9,  ALU_EQ  = 4'd10, ALU_NE  = 4'd11,
    ALU_GE  = 4'd12, ALU_GEU = 4'd13
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      alu_ops,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      funct3,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_shamt_rs2, w_shamt_imm;
  logic [XLEN-1:0] w_op1, w_op2, w_imm;
  alu_op_e         w_alu;
  logic            w_we, w_br, w_jal, w_jalr, w_mr, w_mw, w_ill;
  logic            w_capture;

  logic            r_valid;
  logic [XLEN-1:0] r_op1, r_op2, r_imm, r_pc;
  alu_op_e         r_alu;
  logic [4:0]      r_rd;
  logic [2:0]      r_f3;
  logic            r_we, r_br, r_jal, r_jalr, r_mr, r_mw, r_ill;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'h000};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  // The ALU shifts by the full op2, so shift amounts must be masked to 5 bits here.
  assign w_shamt_rs2 = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
  assign w_shamt_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    w_op1  = '0;
    w_op2  = '0;
    w_imm  = '0;
    w_alu  = ALU_ADD;
    w_we   = 1'b0;
    w_br   = 1'b0;
    w_jal  = 1'b0;
    w_jalr = 1'b0;
    w_mr   = 1'b0;
    w_mw   = 1'b0;
    w_ill  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_op1 = rs1_data;
        w_op2 = rs2_data;
        w_we  = 1'b1;
        w_ill = !((w_f7 == 7'b0000000) ||
                  (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
        case (w_f3)
          3'b000: w_alu = w_f7[5] ? ALU_SUB : ALU_ADD;
          3'b001: begin w_alu = ALU_SLL; w_op2 = w_shamt_rs2; end
          3'b010: w_alu = ALU_LT;
          3'b011: w_alu = ALU_LTU;
          3'b100: w_alu = ALU_XOR;
          3'b101: begin w_alu = w_f7[5] ? ALU_SRA : ALU_SRL; w_op2 = w_shamt_rs2; end
          3'b110: w_alu = ALU_OR;
          default: w_alu = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        w_op1 = rs1_data;
        w_op2 = w_imm_i;
        w_imm = w_imm_i;
        w_we  = 1'b1;
        case (w_f3)
          3'b000: w_alu = ALU_ADD;
          3'b001: begin
            w_alu = ALU_SLL;
            w_op2 = w_shamt_imm;
            w_ill = (w_f7 != 7'b0000000);
          end
          3'b010: w_alu = ALU_LT;
          3'b011: w_alu = ALU_LTU;
          3'b100: w_alu = ALU_XOR;
          3'b101: begin
            w_alu = w_f7[5] ? ALU_SRA : ALU_SRL;
            w_op2 = w_shamt_imm;
            w_ill = !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
          end
          3'b110: w_alu = ALU_OR;
          default: w_alu = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        w_op1 = rs1_data; w_op2 = w_imm_i; w_imm = w_imm_i; w_mr = 1'b1; w_we = 1'b1;
      end
      OPC_STORE: begin
        w_op1 = rs1_data; w_op2 = w_imm_s; w_imm = w_imm_s; w_mw = 1'b1;
      end
      OPC_BRANCH: begin
        w_op1 = rs1_data;
        w_op2 = rs2_data;
        w_imm = w_imm_b;
        w_br  = 1'b1;
        case (w_f3)
          3'b000: w_alu = ALU_EQ;
          3'b001: w_alu = ALU_NE;
          3'b100: w_alu = ALU_LT;
          3'b101: w_alu = ALU_GE;
          3'b110: w_alu = ALU_LTU;
          3'b111: w_alu = ALU_GEU;
          default: w_ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_op2 = w_imm_u; w_imm = w_imm_u; w_we = 1'b1;
      end
      OPC_AUIPC: begin
        w_op1 = in_pc; w_op2 = w_imm_u; w_imm = w_imm_u; w_we = 1'b1;
      end
      OPC_JAL: begin
        w_op1 = in_pc; w_op2 = XLEN'(4); w_imm = w_imm_j; w_jal = 1'b1; w_we = 1'b1;
      end
      OPC_JALR: begin
        w_op1 = in_pc; w_op2 = XLEN'(4); w_imm = w_imm_i; w_jalr = 1'b1; w_we = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // An illegal instruction still flows downstream but must have no side effects.
    if (w_ill) begin
      w_we   = 1'b0;
      w_br   = 1'b0;
      w_jal  = 1'b0;
      w_jalr = 1'b0;
      w_mr   = 1'b0;
      w_mw   = 1'b0;
    end
    if (in_instr[11:7] == 5'd0) w_we = 1'b0;
  end

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_alu   <= ALU_ADD;
      r_rd    <= '0;
      r_f3    <= '0;
      r_we    <= 1'b0;
      r_br    <= 1'b0;
      r_jal   <= 1'b0;
      r_jalr  <= 1'b0;
      r_mr    <= 1'b0;
      r_mw    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_imm   <= w_imm;
      r_pc    <= in_pc;
      r_alu   <= w_alu;
      r_rd    <= in_instr[11:7];
      r_f3    <= w_f3;
      r_we    <= w_we;
      r_br    <= w_br;
      r_jal   <= w_jal;
      r_jalr  <= w_jalr;
      r_mr    <= w_mr;
      r_mw    <= w_mw;
      r_ill   <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign alu_ops   = r_alu;
  assign imm       = r_imm;
  assign pc        = r_pc;
  assign rd        = r_rd;
  assign rd_we     = r_we;
  assign is_branch = r_br;
  assign is_jal    = r_jal;
  assign is_jalr   = r_jalr;
  assign mem_read  = r_mr;
  assign mem_write = r_mw;
  assign funct3    = r_f3;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: expected bundles are queued when an
// instruction is offered and compared when the stage presents them.

module tb_decode_stage;

  localparam logic [3:0] A_ADD = 4'd0,  A_SUB = 4'd1,  A_SLL = 4'd2,  A_LT  = 4'd3;
  localparam logic [3:0] A_SRA = 4'd7,  A_GE  = 4'd12;

  typedef struct {
    logic [31:0] op1, op2, imm, pc;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        we, br, jal, jalr, mr, mw, ill;
    bit          chk_ops, chk_imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data, op1, op2, imm, pc;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [3:0]  alu_ops;
  logic [2:0]  funct3;
  logic        rd_we, is_branch, is_jal, is_jalr, mem_read, mem_write, illegal;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sb[$];

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op1(op1), .op2(op2), .alu_ops(alu_ops), .imm(imm), .pc(pc),
    .rd(rd), .rd_we(rd_we), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] o1, o2, im, p, input logic [3:0] alu,
                              input logic [4:0] r, input logic [2:0] f3,
                              input logic we, br, jal, jalr, mr, mw, ill,
                              input bit cops, cimm);
    exp_t e;
    e.op1 = o1; e.op2 = o2; e.imm = im; e.pc = p; e.alu = alu; e.rd = r; e.f3 = f3;
    e.we = we; e.br = br; e.jal = jal; e.jalr = jalr; e.mr = mr; e.mw = mw; e.ill = ill;
    e.chk_ops = cops; e.chk_imm = cimm;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, p, d1, d2,
                       input logic ordy, input logic fl);
    in_valid = v; in_instr = instr; in_pc = p; rs1_data = d1; rs2_data = d2;
    out_ready = ordy; flush = fl;
  endtask

  task automatic check_front(input string tag, input bit do_pop);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected a queued bundle", tag);
    end else begin
      e = sb[0];
      chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      if (e.chk_ops) begin
        chk({tag, ".op1"}, op1, e.op1);
        chk({tag, ".op2"}, op2, e.op2);
        chk({tag, ".alu_ops"}, {28'd0, alu_ops}, {28'd0, e.alu});
      end
      if (e.chk_imm) chk({tag, ".imm"}, imm, e.imm);
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
      chk({tag, ".funct3"}, {29'd0, funct3}, {29'd0, e.f3});
      chk({tag, ".flags"},
          {25'd0, rd_we, is_branch, is_jal, is_jalr, mem_read, mem_write, illegal},
          {25'd0, e.we, e.br, e.jal, e.jalr, e.mr, e.mw, e.ill});
      if (do_pop) void'(sb.pop_front());
    end
  endtask

  // Offer one instruction with execute ready; it must be captured and shown next cycle.
  task automatic issue(input string tag, input logic [31:0] instr, p, d1, d2, input exp_t e);
    drive(1'b1, instr, p, d1, d2, 1'b1, 1'b0);
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".rs1_addr"}, {27'd0, rs1_addr}, {27'd0, instr[19:15]});
    chk({tag, ".rs2_addr"}, {27'd0, rs2_addr}, {27'd0, instr[24:20]});
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    check_front(tag, 1'b1);
  endtask

  initial begin
    exp_t ea, eb;
    ea = mk(32'h10, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0, A_ADD, 5'd1, 3'd0,
            1, 0, 0, 0, 0, 0, 0, 1, 1);
    eb = mk(32'h8000_0000, 32'h3, 32'h0, 32'h4, A_SRA, 5'd3, 3'd5,
            1, 0, 0, 0, 0, 0, 0, 1, 0);

    rst_n = 1'b0;
    drive(1'b1, 32'hFFB1_0093, 32'h0, 32'h10, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.op1", op1, 32'd0);
    chk("reset.op2", op2, 32'd0);
    chk("reset.alu_ops", {28'd0, alu_ops}, {28'd0, A_ADD});
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("idle.out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back decode of every instruction class
    chk("addi.rs1_addr_pre", {27'd0, rs1_addr}, 32'd2);
    issue("addi", 32'hFFB1_0093, 32'h0, 32'h10, 32'h0, ea);
    issue("sra", 32'h4052_51B3, 32'h4, 32'h8000_0000, 32'h23, eb);
    issue("sub", 32'h4020_81B3, 32'h8, 32'h5, 32'h7,
          mk(32'h5, 32'h7, 0, 32'h8, A_SUB, 5'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    issue("sll", 32'h0020_91B3, 32'hC, 32'h1, 32'hFFFF_FFE5,
          mk(32'h1, 32'h5, 0, 32'hC, A_SLL, 5'd3, 3'd1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    issue("lui", 32'h1234_53B7, 32'h10, 32'hDEAD_BEEF, 32'h0,
          mk(32'h0, 32'h1234_5000, 32'h1234_5000, 32'h10, A_ADD, 5'd7, 3'd5,
             1, 0, 0, 0, 0, 0, 0, 1, 1));
    issue("auipc", 32'h0000_1417, 32'h100, 32'h0, 32'h0,
          mk(32'h100, 32'h1000, 32'h1000, 32'h100, A_ADD, 5'd8, 3'd1,
             1, 0, 0, 0, 0, 0, 0, 1, 1));
    issue("blt", 32'h0020_C463, 32'h104, 32'hAAAA, 32'h5555,
          mk(32'hAAAA, 32'h5555, 32'h8, 32'h104, A_LT, 5'd8, 3'd4,
             0, 1, 0, 0, 0, 0, 0, 1, 1));
    issue("bge_neg", 32'hFE20_DEE3, 32'h108, 32'h1, 32'h2,
          mk(32'h1, 32'h2, 32'hFFFF_FFFC, 32'h108, A_GE, 5'd29, 3'd5,
             0, 1, 0, 0, 0, 0, 0, 1, 1));
    issue("jal", 32'h0100_00EF, 32'h200, 32'h0, 32'h0,
          mk(32'h200, 32'h4, 32'h10, 32'h200, A_ADD, 5'd1, 3'd0,
             1, 0, 1, 0, 0, 0, 0, 1, 1));
    issue("jalr_x0", 32'h0000_8067, 32'h300, 32'h444, 32'h0,
          mk(32'h300, 32'h4, 32'h0, 32'h300, A_ADD, 5'd0, 3'd0,
             0, 0, 0, 1, 0, 0, 0, 1, 1));
    issue("lw", 32'hFFC1_2283, 32'h304, 32'h1000, 32'h0,
          mk(32'h1000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h304, A_ADD, 5'd5, 3'd2,
             1, 0, 0, 0, 1, 0, 0, 1, 1));
    issue("sw", 32'h0031_2423, 32'h308, 32'h2000, 32'h77,
          mk(32'h2000, 32'h8, 32'h8, 32'h308, A_ADD, 5'd8, 3'd2,
             0, 0, 0, 0, 0, 1, 0, 1, 1));
    issue("srai", 32'h4030_D093, 32'h30C, 32'hF0, 32'h0,
          mk(32'hF0, 32'h3, 32'h403, 32'h30C, A_SRA, 5'd1, 3'd5,
             1, 0, 0, 0, 0, 0, 0, 1, 1));
    issue("addi_x0", 32'h0010_0013, 32'h310, 32'h0, 32'h0,
          mk(32'h0, 32'h1, 32'h1, 32'h310, A_ADD, 5'd0, 3'd0,
             0, 0, 0, 0, 0, 0, 0, 1, 1));
    issue("ill_opc", 32'h0000_007F, 32'h314, 32'h0, 32'h0,
          mk(0, 0, 0, 32'h314, A_ADD, 5'd0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    issue("ill_slli", 32'h4010_9093, 32'h318, 32'h0, 32'h0,
          mk(0, 0, 0, 32'h318, A_ADD, 5'd1, 3'd1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    issue("ill_br010", 32'h0020_A463, 32'h31C, 32'h0, 32'h0,
          mk(0, 0, 0, 32'h31C, A_ADD, 5'd8, 3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    issue("ill_f7", 32'h0220_80B3, 32'h320, 32'h0, 32'h0,
          mk(0, 0, 0, 32'h320, A_ADD, 5'd1, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: held bundle must stay bit-stable while a new one waits
    drive(1'b1, 32'hFFB1_0093, 32'h0, 32'h10, 32'h0, 1'b1, 1'b0);
    sb.push_back(ea);
    tick();
    check_front("bp.first", 1'b0);
    drive(1'b1, 32'h4052_51B3, 32'h4, 32'h8000_0000, 32'h23, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check_front("bp.hold", 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(eb);
    tick();
    void'(sb.pop_front());
    in_valid = 1'b0;
    check_front("bp.second", 1'b1);
    tick();
    chk("bp.drain", {31'd0, out_valid}, 32'd0);

    // Flush beats a simultaneous capture
    drive(1'b1, 32'hFFB1_0093, 32'h0, 32'h10, 32'h0, 1'b1, 1'b0);
    sb.push_back(ea);
    tick();
    check_front("fl.first", 1'b1);
    drive(1'b1, 32'h4052_51B3, 32'h4, 32'h8000_0000, 32'h23, 1'b1, 1'b1);
    tick();
    chk("fl.out_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("fl.no_capture", {31'd0, out_valid}, 32'd0);

    // Flush while stalled drops the held bundle
    drive(1'b1, 32'h4052_51B3, 32'h4, 32'h8000_0000, 32'h23, 1'b1, 1'b0);
    sb.push_back(eb);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check_front("fls.hold", 1'b0);
    flush = 1'b1;
    tick();
    chk("fls.out_valid", {31'd0, out_valid}, 32'd0);
    void'(sb.pop_front());
    flush = 1'b0;

    // Reset while stalled
    drive(1'b1, 32'hFFB1_0093, 32'h0, 32'h10, 32'h0, 1'b1, 1'b0);
    sb.push_back(ea);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check_front("rs.hold", 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rs.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs.op1", op1, 32'd0);
    chk("rs.imm", imm, 32'd0);
    chk("rs.rd_we", {31'd0, rd_we}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
